// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage and the ALU it feeds.
//   alu_op_e        : ALU opcode encoding (ADD/SUB/MOV/LSL)
//   Flag*           : bit positions of N, Z, C, V in the 4-bit status word
//   DefaultDataW    : default operand width
//   DefaultNregs    : default register count (power of two)
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMov = 2'd2,
    OpLsl = 2'd3
  } alu_op_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultNregs = 16;

endpackage

// File: rtl/regfile.sv
// NREGS x DATA_W register file with one write port and two bypassed read ports.
//   clk_i, rst_i            : clock, synchronous active-high reset (clears every entry)
//   wr_en_i/wr_addr_i/wr_data_i : write port, takes effect at the rising edge
//   rd_addr1_i/rd_addr2_i   : read addresses
//   rd_data1_o/rd_data2_o   : read data; a same-cycle write to the read address is forwarded
module regfile
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned NREGS  = DefaultNregs,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr1_i,
  input  logic [AW-1:0]     rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register 0 is an ordinary writable register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data1_o = regs_q[rd_addr1_i];
    rd_data2_o = regs_q[rd_addr2_i];
    if (wr_en_i && (wr_addr_i == rd_addr1_i)) begin
      rd_data1_o = wr_data_i;
    end
    if (wr_en_i && (wr_addr_i == rd_addr2_i)) begin
      rd_data2_o = wr_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads source operands from the register file, selects the
// immediate for operand 2 when requested, and holds the result in a one-deep
// valid/ready pipeline register feeding the ALU. Also keeps the NZCV flag register.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   issue_valid_i/issue_ready_o  : upstream handshake
//   rs1_i, rs2_i, imm_i, use_imm_i, opcode_i, signed_i, set_status_i, rd_i, rd_we_i
//                                : instruction fields
//   ex_valid_o/ex_ready_i        : downstream handshake
//   data1_o, data2_o, opcode_o, signed_o, set_status_o, rd_o, rd_we_o
//                                : registered instruction presented to the ALU
//   wr_en_i, wr_addr_i, wr_data_i: register writeback
//   status_we_i, status_i        : flag writeback
//   flags_o                      : current NZCV flags
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned NREGS  = DefaultNregs,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [AW-1:0]     rs1_i,
  input  logic [AW-1:0]     rs2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              use_imm_i,
  input  logic [1:0]        opcode_i,
  input  logic              signed_i,
  input  logic              set_status_i,
  input  logic [AW-1:0]     rd_i,
  input  logic              rd_we_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [1:0]        opcode_o,
  output logic              signed_o,
  output logic              set_status_o,
  output logic [AW-1:0]     rd_o,
  output logic              rd_we_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              status_we_i,
  input  logic [3:0]        status_i,
  output logic [3:0]        flags_o
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  alu_op_e           opcode_q, opcode_d;
  logic              signed_q, signed_d;
  logic              set_status_q, set_status_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  // Source addresses of the held instruction, kept for stall refresh.
  logic [AW-1:0]     rs1_q, rs1_d;
  logic [AW-1:0]     rs2_q, rs2_d;
  logic              use_imm_q, use_imm_d;
  logic [3:0]        flags_q, flags_d;

  logic              fire;
  logic              stall;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rd_data1, rd_data2;

  // Writeback is suppressed while in reset so it cannot land after the clear.
  assign rf_wr_en = wr_en_i && !rst_i;

  regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (rf_wr_en),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_addr1_i (rs1_i),
    .rd_addr2_i (rs2_i),
    .rd_data1_o (rd_data1),
    .rd_data2_o (rd_data2)
  );

  assign issue_ready_o = !ex_valid_q || ex_ready_i;
  assign fire          = issue_valid_i && issue_ready_o;
  assign stall         = ex_valid_q && !ex_ready_i;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    opcode_d     = opcode_q;
    signed_d     = signed_q;
    set_status_d = set_status_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    use_imm_d    = use_imm_q;
    flags_d      = status_we_i ? status_i : flags_q;

    if (fire) begin
      ex_valid_d   = 1'b1;
      data1_d      = rd_data1;
      data2_d      = use_imm_i ? imm_i : rd_data2;
      opcode_d     = alu_op_e'(opcode_i);
      signed_d     = signed_i;
      set_status_d = set_status_i;
      rd_d         = rd_i;
      rd_we_d      = rd_we_i;
      rs1_d        = rs1_i;
      rs2_d        = rs2_i;
      use_imm_d    = use_imm_i;
    end else if (stall) begin
      // A writeback landing on a held source must not leave the ALU with stale data.
      if (wr_en_i && (wr_addr_i == rs1_q)) begin
        data1_d = wr_data_i;
      end
      if (wr_en_i && !use_imm_q && (wr_addr_i == rs2_q)) begin
        data2_d = wr_data_i;
      end
    end else if (ex_valid_q) begin
      // Consumed with nothing behind it: drop valid, keep fields.
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      opcode_q     <= OpAdd;
      signed_q     <= 1'b0;
      set_status_q <= 1'b0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      use_imm_q    <= 1'b0;
      flags_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      opcode_q     <= opcode_d;
      signed_q     <= signed_d;
      set_status_q <= set_status_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      use_imm_q    <= use_imm_d;
      flags_q      <= flags_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign data1_o      = data1_q;
  assign data2_o      = data2_q;
  assign opcode_o     = opcode_q;
  assign signed_o     = signed_q;
  assign set_status_o = set_status_q;
  assign rd_o         = rd_q;
  assign rd_we_o      = rd_we_q;
  assign flags_o      = flags_q;

endmodule
